// File: rtl/izhikevich_pkg.sv
// izhikevich_pkg: widths, neuron constants and the W-bit fit (wrap, or clamp when IZH_SATURATE_EN is defined)
package izhikevich_pkg;
   localparam int W    = 17;
   localparam int FRAC = 8;
   localparam int WD   = 2 * W + 8;
   localparam logic signed [W-1:0] K04      = 17'sd10;
   localparam logic signed [W-1:0] K5       = 17'sd1280;
   localparam logic signed [W-1:0] K140     = 17'sd35840;
   localparam logic signed [W-1:0] V_THRESH = 17'sd7680;
   localparam logic signed [WD-1:0] FIT_MAX = WD'((2 ** (W - 1)) - 1);
   localparam logic signed [WD-1:0] FIT_MIN = -FIT_MAX - 1;
   function automatic logic [W-1:0] fit(input logic signed [WD-1:0] x);
`ifdef IZH_SATURATE_EN
      return x > FIT_MAX ? {1'b0, {(W-1){1'b1}}} :
             x < FIT_MIN ? {1'b1, {(W-1){1'b0}}} : x[W-1:0];
`else
      return x[W-1:0];
`endif
   endfunction
endpackage

// File: rtl/izh_fxmul.sv
// izh_fxmul: signed fixed-point multiply, full product rescaled by arithmetic shift (floor)
module izh_fxmul
   import izhikevich_pkg::*;
#(
   parameter int AW = W,
   parameter int BW = W,
   parameter int OW = WD
) (
   input  logic signed [AW-1:0] a_i,
   input  logic signed [BW-1:0] b_i,
   output logic signed [OW-1:0] p_o
);
   logic signed [AW+BW-1:0] prod;
   assign prod = a_i * b_i;
   assign p_o  = OW'(prod >>> FRAC);
endmodule

// File: rtl/izhikevich.sv
// izhikevich: one Euler step of the Izhikevich neuron, registered outputs (IZH_SATURATE_EN selects clamping fit)
module izhikevich
   import izhikevich_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] c,
   input  logic signed [W-1:0] d,
   input  logic signed [W-1:0] v,
   input  logic signed [W-1:0] u,
   input  logic signed [W-1:0] i,
   output logic signed [W-1:0] v_prime,
   output logic signed [W-1:0] u_prime,
   output logic                fired
);
   logic signed [WD-1:0] vv, kvv, bv, diff, adiff, v5, vn, un;
   logic [W-1:0] v_prime_d, v_prime_q, u_prime_d, u_prime_q;
   logic         fired_d, fired_q;

   izh_fxmul #(.AW(W), .BW(W),  .OW(WD)) u_vv  (.a_i(v),   .b_i(v),    .p_o(vv));
   izh_fxmul #(.AW(W), .BW(WD), .OW(WD)) u_kvv (.a_i(K04), .b_i(vv),   .p_o(kvv));
   izh_fxmul #(.AW(W), .BW(W),  .OW(WD)) u_bv  (.a_i(b),   .b_i(v),    .p_o(bv));
   izh_fxmul #(.AW(W), .BW(WD), .OW(WD)) u_adu (.a_i(a),   .b_i(diff), .p_o(adiff));

   assign diff = bv - WD'(u);
   assign v5   = (WD'(K5) * WD'(v)) >>> FRAC;
   assign vn   = WD'(v) + kvv + v5 + WD'(K140) - WD'(u) + WD'(i);
   assign un   = WD'(u) + adiff;

   // spike decision on the unsaturated v_n, then select reset or integrated state
   always_comb begin
      fired_d   = vn >= WD'(V_THRESH);
      v_prime_d = fired_d ? c : fit(vn);
      u_prime_d = fired_d ? fit(un + WD'(d)) : fit(un);
   end

   // output register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_prime_q <= '0;
         u_prime_q <= '0;
         fired_q   <= 1'b0;
      end else begin
         v_prime_q <= v_prime_d;
         u_prime_q <= u_prime_d;
         fired_q   <= fired_d;
      end
   end

   assign v_prime = v_prime_q;
   assign u_prime = u_prime_q;
   assign fired   = fired_q;
endmodule

// File: tb/tb_izhikevich.sv
// tb_izhikevich: directed vector table plus async-reset sequences for izhikevich
module tb_izhikevich;
   typedef struct {
      string      nm;
      logic [16:0] a, b, c, d, v, u, i, ev, eu;
      logic        ef;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [16:0] a, b, c, d, v, u, i;
   logic [16:0] v_prime, u_prime;
   logic        fired;
   int checks = 0;
   int failures = 0;
   vec_t vt[6];

   always #5 clk = ~clk;

   izhikevich dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .v(v), .u(u), .i(i),
      .v_prime(v_prime), .u_prime(u_prime), .fired(fired)
   );

   task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      a = x.a; b = x.b; c = x.c; d = x.d; v = x.v; u = x.u; i = x.i;
   endtask

   task automatic chk_out(input vec_t x);
      chk({x.nm, "_v"}, v_prime, x.ev);
      chk({x.nm, "_u"}, u_prime, x.eu);
      chk({x.nm, "_f"}, {16'd0, fired}, {16'd0, x.ef});
   endtask

   initial begin
      vt[0] = '{"subthr", 17'h00300, 17'h01400, 17'h00300, 17'h00300, 17'h00A00, 17'h0B400, 17'h00600, 17'h01DE8, 17'h0F000, 1'b0};
      vt[1] = '{"spike",  17'h00200, 17'h00F00, 17'h02000, 17'h00500, 17'h00A00, 17'h06400, 17'h00600, 17'h02000, 17'h0CD00, 1'b1};
`ifdef IZH_SATURATE_EN
      vt[2] = '{"ovf",    17'h00100, 17'h00200, 17'h00300, 17'h00000, 17'h0C800, 17'h00000, 17'h00000, 17'h00300, 17'h0FFFF, 1'b1};
`else
      vt[2] = '{"ovf",    17'h00100, 17'h00200, 17'h00300, 17'h00000, 17'h0C800, 17'h00000, 17'h00000, 17'h00300, 17'h19000, 1'b1};
`endif
      vt[3] = '{"thr_eq", 17'h00000, 17'h00000, 17'h01100, 17'h00000, 17'h00000, 17'h06E00, 17'h00000, 17'h01100, 17'h06E00, 1'b1};
      vt[4] = '{"thr_lo", 17'h00000, 17'h00000, 17'h01100, 17'h00000, 17'h00000, 17'h06E00, 17'h1FFFF, 17'h01DFF, 17'h06E00, 1'b0};
      vt[5] = '{"floor",  17'h00100, 17'h00080, 17'h00000, 17'h00000, 17'h1FFFF, 17'h00000, 17'h17400, 17'h1FFFA, 17'h1FFFF, 1'b0};

      a = 17'h12345; b = 17'h0ABCD; c = 17'h01111; d = 17'h1F00F; v = 17'h0C800; u = 17'h10001; i = 17'h07777;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_v", v_prime, 17'h0);
      chk("rst_u", u_prime, 17'h0);
      chk("rst_f", {16'd0, fired}, 17'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         drive(vt[k]);
         @(posedge clk);
         #1 chk_out(vt[k]);
         @(negedge clk);
      end
      drive(vt[0]);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_v", v_prime, 17'h0);
      chk("mid_rst_u", u_prime, 17'h0);
      chk("mid_rst_f", {16'd0, fired}, 17'h0);
      @(negedge clk);
      drive(vt[1]);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk_out(vt[1]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
